// File: rtl/uop_engine_pkg.sv
// Shared definitions for the point-arithmetic microcode sequencer and the
// doubling/addition microcode ROMs: opcode encodings, bank codes, execution
// conditions, field layout and a microword packing helper.
package uop_engine_pkg;

  // Microword layout, msb to lsb: opcode | src1 | src2 | dst | exec
  localparam int UOP_OPC_W    = 6;
  localparam int UOP_BANK_W   = 4;
  localparam int UOP_EXEC_W   = 2;
  localparam int UOP_OPC_LSB  = 14;
  localparam int UOP_SRC1_LSB = 10;
  localparam int UOP_SRC2_LSB = 6;
  localparam int UOP_DST_LSB  = 2;
  localparam int UOP_EXEC_LSB = 0;
  localparam int UOP_FIELDS_W = UOP_OPC_W + 3*UOP_BANK_W + UOP_EXEC_W;

  typedef logic [UOP_OPC_W-1:0]  uop_opc_t;
  typedef logic [UOP_BANK_W-1:0] uop_bank_t;
  typedef logic [UOP_EXEC_W-1:0] uop_exec_t;

  // One-hot opcodes; the low five bits double as the unit select
  localparam uop_opc_t OPCODE_RDY = 6'b10_0000;
  localparam uop_opc_t OPCODE_MUL = 6'b01_0000;
  localparam uop_opc_t OPCODE_SUB = 6'b00_1000;
  localparam uop_opc_t OPCODE_ADD = 6'b00_0100;
  localparam uop_opc_t OPCODE_MOV = 6'b00_0010;
  localparam uop_opc_t OPCODE_CMP = 6'b00_0001;

  // Operand bank codes (point coordinates, temporaries, constants)
  localparam uop_bank_t UOP_SRC_PX = 4'd0;
  localparam uop_bank_t UOP_SRC_PY = 4'd1;
  localparam uop_bank_t UOP_SRC_PZ = 4'd2;
  localparam uop_bank_t UOP_SRC_QX = 4'd3;
  localparam uop_bank_t UOP_SRC_QY = 4'd4;
  localparam uop_bank_t UOP_SRC_QZ = 4'd5;
  localparam uop_bank_t UOP_SRC_T0 = 4'd6;
  localparam uop_bank_t UOP_SRC_T1 = 4'd7;
  localparam uop_bank_t UOP_SRC_T2 = 4'd8;
  localparam uop_bank_t UOP_SRC_T3 = 4'd9;
  localparam uop_bank_t UOP_SRC_A  = 4'd10;
  localparam uop_bank_t UOP_SRC_B  = 4'd11;

  // Destination bank codes (writable banks only)
  localparam uop_bank_t UOP_DST_PX = 4'd0;
  localparam uop_bank_t UOP_DST_PY = 4'd1;
  localparam uop_bank_t UOP_DST_PZ = 4'd2;
  localparam uop_bank_t UOP_DST_T0 = 4'd6;
  localparam uop_bank_t UOP_DST_T1 = 4'd7;
  localparam uop_bank_t UOP_DST_T2 = 4'd8;
  localparam uop_bank_t UOP_DST_T3 = 4'd9;

  // Execution conditions; the two upper codes are reserved and never execute
  localparam uop_exec_t UOP_EXEC_ALWAYS = 2'b00;
  localparam uop_exec_t UOP_EXEC_IF_EQ  = 2'b01;
  localparam uop_exec_t UOP_EXEC_RSV2   = 2'b10;
  localparam uop_exec_t UOP_EXEC_RSV3   = 2'b11;

  // Field order matches the microword bit order, so a cast splits a word
  typedef struct packed {
    uop_opc_t  opc;
    uop_bank_t src1;
    uop_bank_t src2;
    uop_bank_t dst;
    uop_exec_t exec;
  } uop_fields_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_ISSUE, ST_WAIT, ST_DONE
  } uop_state_e;

  function automatic logic uop_onehot(input uop_opc_t x);
    return (x != '0) && ((x & (x - uop_opc_t'(1))) == '0);
  endfunction

  function automatic logic [UOP_FIELDS_W-1:0] uop_pack(
    input uop_opc_t opc, input uop_bank_t s1, input uop_bank_t s2,
    input uop_bank_t d, input uop_exec_t ex);
    return {opc, s1, s2, d, ex};
  endfunction

endpackage

// File: rtl/uop_engine_if.sv
// Sequencer bus: start/ready handshake, microcode ROM port and the
// operation issue port to the arithmetic/move/compare units.
// err exists only when UOP_ENGINE_WATCHDOG_EN is defined.
interface uop_engine_if #(
  parameter int UOP_ADDR_W = 6,
  parameter int UOP_W      = 20
);
  logic                  ena;
  logic                  rdy;
  logic [UOP_ADDR_W-1:0] uop_addr;
  logic [UOP_W-1:0]      uop_data;
  logic                  op_ena;
  logic [4:0]            op_sel;
  logic [3:0]            op_src1;
  logic [3:0]            op_src2;
  logic [3:0]            op_dst;
  logic                  op_done;
  logic                  cmp_eq;
`ifdef UOP_ENGINE_WATCHDOG_EN
  logic                  err;
`endif

  // Sequencer side
  modport master (
    input  ena, uop_data, op_done, cmp_eq,
`ifdef UOP_ENGINE_WATCHDOG_EN
    output err,
`endif
    output rdy, uop_addr, op_ena, op_sel, op_src1, op_src2, op_dst
  );

  // Environment side: host, ROM and execution units
  modport slave (
    output ena, uop_data, op_done, cmp_eq,
`ifdef UOP_ENGINE_WATCHDOG_EN
    input  err,
`endif
    input  rdy, uop_addr, op_ena, op_sel, op_src1, op_src2, op_dst
  );
endinterface

// File: rtl/uop_engine_decode.sv
// Combinational microword decoder: splits the fields, flags words that end
// the program (RDY or any non-one-hot opcode) and evaluates the execution
// condition against the current compare flag.
module uop_decode
  import uop_engine_pkg::*;
#(
  parameter int UOP_W = 20
) (
  input  logic [UOP_W-1:0] uop_i,
  input  logic             cmp_flag_i,
  output logic [4:0]       sel_o,
  output uop_bank_t        src1_o,
  output uop_bank_t        src2_o,
  output uop_bank_t        dst_o,
  output logic             term_o,
  output logic             exec_o
);

  uop_fields_t fld;

  // Field split, termination and condition evaluation
  always_comb begin
    fld    = uop_fields_t'(uop_i[UOP_FIELDS_W-1:0]);
    sel_o  = fld.opc[4:0];
    src1_o = fld.src1;
    src2_o = fld.src2;
    dst_o  = fld.dst;
    term_o = !uop_onehot(fld.opc) || fld.opc[5];
    case (fld.exec)
      UOP_EXEC_ALWAYS: exec_o = 1'b1;
      UOP_EXEC_IF_EQ:  exec_o = cmp_flag_i;
      default:         exec_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/uop_engine.sv
// Microcode sequencer for the curve point arithmetic cores. Fetches words
// from a registered ROM, decodes them and issues one operation at a time,
// waiting for the unit's completion pulse. Terminates on RDY, on an illegal
// opcode, or after the last address without wrapping.
// Optional UOP_ENGINE_WATCHDOG_EN adds err and a WDT_CYCLES wait timeout.
module uop_engine
  import uop_engine_pkg::*;
#(
  parameter int UOP_ADDR_W = 6,
  parameter int UOP_W      = 20
`ifdef UOP_ENGINE_WATCHDOG_EN
  ,
  parameter int WDT_CYCLES = 4096
`endif
) (
  input  logic          clk,
  input  logic          rst,
  uop_engine_if.master  bus
);

  localparam logic [UOP_ADDR_W-1:0] ADDR_LAST = '1;

  uop_state_e            state_q;
  logic [UOP_ADDR_W-1:0] addr_q;
  logic                  rdy_q;
  logic                  op_ena_q;
  logic [4:0]            op_sel_q;
  uop_bank_t             src1_q;
  uop_bank_t             src2_q;
  uop_bank_t             dst_q;
  logic                  cmp_q;

  logic [4:0]            dec_sel;
  uop_bank_t             dec_src1;
  uop_bank_t             dec_src2;
  uop_bank_t             dec_dst;
  logic                  dec_term;
  logic                  dec_exec;

`ifdef UOP_ENGINE_WATCHDOG_EN
  localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  logic             err_q;
  logic [WDT_W-1:0] wdt_q;
`endif

  uop_decode #(.UOP_W(UOP_W)) u_dec (
    .uop_i      (bus.uop_data),
    .cmp_flag_i (cmp_q),
    .sel_o      (dec_sel),
    .src1_o     (dec_src1),
    .src2_o     (dec_src2),
    .dst_o      (dec_dst),
    .term_o     (dec_term),
    .exec_o     (dec_exec)
  );

  // Sequencer FSM; every output is a register driven from here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      rdy_q    <= 1'b1;
      op_ena_q <= 1'b0;
      op_sel_q <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      dst_q    <= '0;
      cmp_q    <= 1'b0;
`ifdef UOP_ENGINE_WATCHDOG_EN
      err_q    <= 1'b0;
      wdt_q    <= '0;
`endif
    end else begin
      op_ena_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.ena && rdy_q) begin
            addr_q  <= '0;
            rdy_q   <= 1'b0;
            cmp_q   <= 1'b0;
`ifdef UOP_ENGINE_WATCHDOG_EN
            err_q   <= 1'b0;
`endif
            state_q <= ST_FETCH;
          end
        end
        // ROM output lags the address by one cycle
        ST_FETCH: state_q <= ST_DECODE;
        ST_DECODE: begin
          if (dec_term) begin
            state_q <= ST_DONE;
          end else if (!dec_exec) begin
            // skipped word: advance, but never wrap back to address 0
            if (addr_q == ADDR_LAST) begin
              state_q <= ST_DONE;
            end else begin
              addr_q  <= addr_q + UOP_ADDR_W'(1);
              state_q <= ST_FETCH;
            end
          end else begin
            op_sel_q <= dec_sel;
            src1_q   <= dec_src1;
            src2_q   <= dec_src2;
            dst_q    <= dec_dst;
            op_ena_q <= 1'b1;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
`ifdef UOP_ENGINE_WATCHDOG_EN
          wdt_q   <= '0;
`endif
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.op_done) begin
            if (op_sel_q[0]) cmp_q <= bus.cmp_eq;
            if (addr_q == ADDR_LAST) begin
              state_q <= ST_DONE;
            end else begin
              addr_q  <= addr_q + UOP_ADDR_W'(1);
              state_q <= ST_FETCH;
            end
          end
`ifdef UOP_ENGINE_WATCHDOG_EN
          else if (wdt_q == WDT_W'(WDT_CYCLES - 1)) begin
            err_q   <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            wdt_q <= wdt_q + WDT_W'(1);
          end
`endif
        end
        ST_DONE: begin
          rdy_q    <= 1'b1;
          op_sel_q <= '0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.rdy      = rdy_q;
  assign bus.uop_addr = addr_q;
  assign bus.op_ena   = op_ena_q;
  assign bus.op_sel   = op_sel_q;
  assign bus.op_src1  = src1_q;
  assign bus.op_src2  = src2_q;
  assign bus.op_dst   = dst_q;
`ifdef UOP_ENGINE_WATCHDOG_EN
  assign bus.err      = err_q;
`endif

endmodule

// File: tb/tb_uop_engine.sv
// Directed bench for uop_engine: registered ROM model, a unit responder that
// returns op_done a programmable number of cycles after op_ena, and a monitor
// logging issued operations and the address sequence.
module tb_uop_engine;
  import uop_engine_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uop_engine_if #(.UOP_ADDR_W(6), .UOP_W(20)) bus();

`ifdef UOP_ENGINE_WATCHDOG_EN
  uop_engine #(.UOP_ADDR_W(6), .UOP_W(20), .WDT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`else
  uop_engine #(.UOP_ADDR_W(6), .UOP_W(20)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif

  logic [19:0] rom [64];

  // Registered ROM: data follows the address by one cycle
  always @(posedge clk) bus.uop_data <= rom[bus.uop_addr];

  int errors = 0;
  int checks = 0;
  int ena_cnt = 0;
  int addr_n = 0;
  int last_addr = -1;
  logic [4:0] sel_log [64];
  logic [3:0] src1_log [64];
  logic [3:0] dst_log [64];
  logic [5:0] addr_log [128];
  int  resp_dly = 3;
  bit  resp_hold = 1'b0;
  bit  spur = 1'b0;
  bit  pending = 1'b0;
  int  rcnt = 0;

  // Monitor plus unit responder, evaluated away from the active edge
  always @(negedge clk) begin
    if (bus.rdy === 1'b0 && int'(bus.uop_addr) != last_addr) begin
      if (addr_n < 128) addr_log[addr_n] = bus.uop_addr;
      addr_n++;
      last_addr = int'(bus.uop_addr);
    end
    bus.op_done = 1'b0;
    if (rst) begin
      pending = 1'b0;
    end else begin
      if (pending && !resp_hold) begin
        rcnt--;
        if (rcnt == 0) begin
          bus.op_done = 1'b1;
          pending = 1'b0;
        end
      end
      if (bus.op_ena === 1'b1) begin
        if (ena_cnt < 64) begin
          sel_log[ena_cnt]  = bus.op_sel;
          src1_log[ena_cnt] = bus.op_src1;
          dst_log[ena_cnt]  = bus.op_dst;
        end
        ena_cnt++;
        pending = 1'b1;
        rcnt = resp_dly;
        if (spur) bus.op_done = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_rom(input logic [19:0] w);
    for (int i = 0; i < 64; i++) rom[i] = w;
  endtask

  task automatic start();
    ena_cnt = 0;
    addr_n = 0;
    last_addr = -1;
    @(negedge clk);
    bus.ena = 1'b1;
    @(negedge clk);
    bus.ena = 1'b0;
  endtask

  // Counts cycles with rdy low from the first FETCH cycle
  task automatic wait_rdy(input string tag, output int cyc);
    cyc = 0;
    while (bus.rdy !== 1'b1 && cyc < 3000) begin
      cyc++;
      @(negedge clk);
    end
    chk(tag, {31'd0, bus.rdy}, 32'd1);
  endtask

  task automatic wait_ena(input string tag, input int n);
    int k;
    k = 0;
    while (ena_cnt < n && k < 100) begin
      k++;
      @(negedge clk);
    end
    chk(tag, ena_cnt, n);
  endtask

  logic [19:0] w_rdy;
  int cyc;
  logic [5:0] a_hold;
  uop_opc_t ops [4];

  initial begin
    w_rdy = uop_pack(OPCODE_RDY, 4'd0, 4'd0, 4'd0, UOP_EXEC_ALWAYS);
    ops[0] = OPCODE_MUL; ops[1] = OPCODE_SUB; ops[2] = OPCODE_ADD; ops[3] = OPCODE_MOV;
    fill_rom(w_rdy);
    rst = 1'b1;
    bus.ena = 1'b0;
    bus.cmp_eq = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdy",    {31'd0, bus.rdy}, 32'd1);
    chk("rst_addr",   {26'd0, bus.uop_addr}, 32'd0);
    chk("rst_op_ena", {31'd0, bus.op_ena}, 32'd0);
    chk("rst_op_sel", {27'd0, bus.op_sel}, 32'd0);
    chk("rst_banks",  {20'd0, bus.op_src1, bus.op_src2, bus.op_dst}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Straight line MOV, ADD, RDY with op_done three cycles after op_ena
    rom[0] = uop_pack(OPCODE_MOV, UOP_SRC_PX, UOP_SRC_PY, UOP_DST_T0, UOP_EXEC_ALWAYS);
    rom[1] = uop_pack(OPCODE_ADD, UOP_SRC_T1, UOP_SRC_PZ, UOP_DST_T3, UOP_EXEC_ALWAYS);
    rom[2] = w_rdy;
    start();
    wait_rdy("sl_rdy", cyc);
    chk("sl_ena_cnt", ena_cnt, 2);
    chk("sl_sel0", {27'd0, sel_log[0]}, 32'h02);
    chk("sl_sel1", {27'd0, sel_log[1]}, 32'h04);
    chk("sl_src1_1", {28'd0, src1_log[1]}, 32'd7);
    chk("sl_dst0", {28'd0, dst_log[0]}, 32'd6);
    chk("sl_addr_n", addr_n, 3);
    chk("sl_addr_seq", {8'd0, 2'd0, addr_log[0], 2'd0, addr_log[1], 2'd0, addr_log[2]}, 32'h00000102);
    chk("sl_cycles", cyc, 15);
    chk("sl_sel_idle", {27'd0, bus.op_sel}, 32'd0);

    // Minimum costs: executed word 4 cycles, skipped word 2 cycles
    resp_dly = 1;
    fill_rom(w_rdy);
    rom[0] = uop_pack(OPCODE_MOV, UOP_SRC_QX, UOP_SRC_QY, UOP_DST_PX, UOP_EXEC_ALWAYS);
    start();
    wait_rdy("min_rdy", cyc);
    chk("min_exec_cycles", cyc, 7);
    rom[0] = uop_pack(OPCODE_MOV, UOP_SRC_QX, UOP_SRC_QY, UOP_DST_PX, UOP_EXEC_RSV2);
    start();
    wait_rdy("min_skip_rdy", cyc);
    chk("min_skip_cycles", cyc, 5);
    chk("min_skip_ena", ena_cnt, 0);
    resp_dly = 3;

    // CMP then conditional MOV, with equal and not-equal results
    fill_rom(w_rdy);
    rom[0] = uop_pack(OPCODE_CMP, UOP_SRC_T0, UOP_SRC_T1, UOP_DST_T0, UOP_EXEC_ALWAYS);
    rom[1] = uop_pack(OPCODE_MOV, UOP_SRC_T2, UOP_SRC_T2, UOP_DST_PY, UOP_EXEC_IF_EQ);
    bus.cmp_eq = 1'b1;
    start();
    wait_rdy("cmp1_rdy", cyc);
    chk("cmp1_ena_cnt", ena_cnt, 2);
    chk("cmp1_sel0", {27'd0, sel_log[0]}, 32'h01);
    chk("cmp1_sel1", {27'd0, sel_log[1]}, 32'h02);
    bus.cmp_eq = 1'b0;
    start();
    wait_rdy("cmp0_rdy", cyc);
    chk("cmp0_ena_cnt", ena_cnt, 1);
    chk("cmp0_cycles", cyc, 11);

    // Flag set by one program must not survive into the next
    bus.cmp_eq = 1'b1;
    start();
    wait_rdy("flag_set_rdy", cyc);
    rom[0] = uop_pack(OPCODE_MOV, UOP_SRC_T2, UOP_SRC_T2, UOP_DST_PY, UOP_EXEC_IF_EQ);
    rom[1] = w_rdy;
    start();
    wait_rdy("flag_clr_rdy", cyc);
    chk("flag_clr_ena", ena_cnt, 0);
    bus.cmp_eq = 1'b0;

    // Doubling-style program: 24 ops, CMP last, three conditional skips
    fill_rom(w_rdy);
    for (int i = 0; i < 23; i++)
      rom[i] = uop_pack(ops[i % 4], 4'(i % 10), 4'((i + 3) % 10), 4'(6 + i % 4), UOP_EXEC_ALWAYS);
    rom[23] = uop_pack(OPCODE_CMP, UOP_SRC_PZ, UOP_SRC_QZ, UOP_DST_T0, UOP_EXEC_ALWAYS);
    for (int i = 24; i < 27; i++)
      rom[i] = uop_pack(OPCODE_MOV, UOP_SRC_T0, UOP_SRC_T1, UOP_DST_PX, UOP_EXEC_IF_EQ);
    start();
    wait_rdy("dbl_rdy", cyc);
    chk("dbl_ena_cnt", ena_cnt, 24);
    chk("dbl_addr_n", addr_n, 28);
    chk("dbl_last_addr", {26'd0, addr_log[27]}, 32'd27);
    chk("dbl_cycles", cyc, 153);
    chk("dbl_sel23", {27'd0, sel_log[23]}, 32'h01);

    // Spurious op_done in the ISSUE cycle must be ignored
    fill_rom(w_rdy);
    rom[0] = uop_pack(OPCODE_MUL, UOP_SRC_PX, UOP_SRC_PX, UOP_DST_T0, UOP_EXEC_ALWAYS);
    rom[1] = uop_pack(OPCODE_SUB, UOP_SRC_T0, UOP_SRC_A, UOP_DST_T1, UOP_EXEC_ALWAYS);
    spur = 1'b1;
    start();
    wait_rdy("spur_rdy", cyc);
    spur = 1'b0;
    chk("spur_ena_cnt", ena_cnt, 2);
    chk("spur_cycles", cyc, 15);

    // ena pulsed during WAIT of the second op: no restart
    resp_dly = 10;
    start();
    wait_ena("midena_issue", 2);
    repeat (2) @(negedge clk);
    a_hold = bus.uop_addr;
    bus.ena = 1'b1;
    @(negedge clk);
    bus.ena = 1'b0;
    repeat (2) @(negedge clk);
    chk("midena_addr", {26'd0, bus.uop_addr}, {26'd0, a_hold});
    chk("midena_addr1", {26'd0, bus.uop_addr}, 32'd1);
    chk("midena_busy", {31'd0, bus.rdy}, 32'd0);
    wait_rdy("midena_rdy", cyc);
    chk("midena_ena_cnt", ena_cnt, 2);

    // Asynchronous reset during WAIT
    resp_dly = 20;
    start();
    wait_ena("rstw_issue", 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstw_rdy", {31'd0, bus.rdy}, 32'd1);
    chk("rstw_sel", {27'd0, bus.op_sel}, 32'd0);
    chk("rstw_addr", {26'd0, bus.uop_addr}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("rstw_no_ena", ena_cnt, 1);
    chk("rstw_idle", {31'd0, bus.rdy}, 32'd1);
    resp_dly = 3;

    // Illegal opcode at address 5 ends the program
    fill_rom(uop_pack(OPCODE_ADD, UOP_SRC_T0, UOP_SRC_T1, UOP_DST_T2, UOP_EXEC_ALWAYS));
    rom[5] = 20'h00000;
    start();
    wait_rdy("ill0_rdy", cyc);
    chk("ill0_ena_cnt", ena_cnt, 5);
    chk("ill0_last_addr", {26'd0, addr_log[5]}, 32'd5);
    chk("ill0_addr_n", addr_n, 6);
    rom[0] = uop_pack(6'b000110, UOP_SRC_T0, UOP_SRC_T1, UOP_DST_T2, UOP_EXEC_ALWAYS);
    start();
    wait_rdy("ill2_rdy", cyc);
    chk("ill2_ena_cnt", ena_cnt, 0);
    chk("ill2_cycles", cyc, 3);

    // No RDY anywhere: terminate after the last address, never wrap
    for (int i = 0; i < 64; i++)
      rom[i] = uop_pack(OPCODE_MOV, UOP_SRC_PX, UOP_SRC_PY, UOP_DST_PZ,
                        (i % 2 == 0) ? UOP_EXEC_RSV2 : UOP_EXEC_RSV3);
    start();
    wait_rdy("wrap_rdy", cyc);
    chk("wrap_ena_cnt", ena_cnt, 0);
    chk("wrap_addr_n", addr_n, 64);
    chk("wrap_cycles", cyc, 129);
    chk("wrap_addr_end", {26'd0, bus.uop_addr}, 32'd63);

`ifdef UOP_ENGINE_WATCHDOG_EN
    // Withheld op_done: watchdog fires after 16 WAIT cycles
    fill_rom(w_rdy);
    rom[0] = uop_pack(OPCODE_MUL, UOP_SRC_PX, UOP_SRC_QX, UOP_DST_T0, UOP_EXEC_ALWAYS);
    resp_hold = 1'b1;
    start();
    wait_rdy("wdt_rdy", cyc);
    chk("wdt_err", {31'd0, bus.err}, 32'd1);
    chk("wdt_cycles", cyc, 20);
    chk("wdt_sel", {27'd0, bus.op_sel}, 32'd0);
    resp_hold = 1'b0;
    pending = 1'b0;
    rom[0] = w_rdy;
    start();
    chk("wdt_err_clr", {31'd0, bus.err}, 32'd0);
    wait_rdy("wdt_clr_rdy", cyc);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
